// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_txrx transmitter/receiver pair.
package uart_pkg;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned MaxDataWidth = 32;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  function automatic int unsigned calc_clks_per_bit(input int unsigned freq,
                                                    input int unsigned baud);
    return freq / baud;
  endfunction

  // Even parity is the XOR of the data bits, odd parity its complement.
  function automatic logic par(input logic [MaxDataWidth-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronised input, mid-bit sampling, framing and parity checks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clks_per_bit = 4166,
  parameter int unsigned data_width   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  baud_en,
  input  logic                  parity_en,
  input  logic                  odd_r_even_parity,
  output logic                  done,
  output logic                  framing_error,
  output logic                  parity_error,
  output logic [data_width-1:0] data_out
);

  localparam int unsigned CntWidth = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int unsigned IdxWidth = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(clks_per_bit - 1);
  localparam logic [CntWidth-1:0] HalfMax =
      (clks_per_bit / 2 > 0) ? CntWidth'(clks_per_bit / 2 - 1) : '0;
  localparam logic [IdxWidth-1:0] IdxMax = IdxWidth'(data_width - 1);

  rx_state_e             state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic [data_width:0]   shift_ext;
  logic                  par_seen_q, par_seen_d;
  logic                  par_bad_q, par_bad_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_q, perr_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  sync1_q, sync_q, prev_q;
  logic                  fall, bit_done, half_done;

  // Requiring a high-to-low transition means a stuck-low line never re-arms the receiver.
  assign fall      = prev_q & ~sync_q;
  assign bit_done  = baud_en && (cnt_q == CntMax);
  assign half_done = baud_en && (cnt_q == HalfMax);
  assign shift_ext = {sync_q, shift_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_seen_d = par_seen_q;
    par_bad_d  = par_bad_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    data_d     = data_q;

    if (state_q != RxIdle && baud_en) begin
      cnt_d = bit_done ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (fall) begin
          state_d = RxStart;
        end
      end
      RxStart: begin
        if (half_done) begin
          cnt_d      = '0;
          idx_d      = '0;
          par_seen_d = 1'b0;
          par_bad_d  = 1'b0;
          state_d    = sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (bit_done) begin
          shift_d = shift_ext[data_width:1];
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxMax) begin
            state_d = parity_en ? RxParity : RxStop;
          end
        end
      end
      RxParity: begin
        if (bit_done) begin
          par_seen_d = 1'b1;
          par_bad_d  = sync_q != par(MaxDataWidth'(shift_q), odd_r_even_parity);
          state_d    = RxStop;
        end
      end
      RxStop: begin
        if (bit_done) begin
          done_d  = 1'b1;
          data_d  = shift_q;
          ferr_d  = ~sync_q;
          perr_d  = par_seen_q & par_bad_q;
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync_q     <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= RxIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_seen_q <= 1'b0;
      par_bad_q  <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      sync1_q    <= rx;
      sync_q     <= sync1_q;
      prev_q     <= sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_seen_q <= par_seen_d;
      par_bad_q  <= par_bad_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
    end
  end

  assign done          = done_q;
  assign framing_error = ferr_q;
  assign parity_error  = perr_q;
  assign data_out      = data_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned clks_per_bit = 4166,
  parameter int unsigned data_width   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  baud_en,
  input  logic                  parity_en,
  input  logic                  odd_r_even_parity,
  input  logic [data_width-1:0] data_in,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned CntWidth = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int unsigned IdxWidth = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(clks_per_bit - 1);
  localparam logic [IdxWidth-1:0] IdxMax = IdxWidth'(data_width - 1);

  tx_state_e             state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  bit_done;

  assign bit_done = baud_en && (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx        = 1'b1;
    busy      = 1'b1;

    if (state_q != TxIdle && baud_en) begin
      cnt_d = bit_done ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      TxIdle: begin
        busy  = 1'b0;
        cnt_d = '0;
        // Frame settings are captured here so later input changes cannot corrupt the frame.
        if (tx_en) begin
          state_d   = TxStart;
          shift_d   = data_in;
          par_en_d  = parity_en;
          par_bit_d = par(MaxDataWidth'(data_in), odd_r_even_parity);
        end
      end
      TxStart: begin
        tx = 1'b0;
        if (bit_done) begin
          state_d = TxData;
          idx_d   = '0;
        end
      end
      TxData: begin
        tx = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxMax) begin
            state_d = par_en_q ? TxParity : TxStop;
          end
        end
      end
      TxParity: begin
        tx = par_bit_q;
        if (bit_done) begin
          state_d = TxStop;
        end
      end
      TxStop: begin
        if (bit_done) begin
          state_d = TxIdle;
        end
      end
      default: state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TxIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART: independent transmitter and receiver on one clock and reset.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq   = 40_000_000,
  parameter int unsigned baud_rate  = 9600,
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  baud_en,
  input  logic                  parity_en,
  input  logic                  odd_r_even_parity,
  input  logic                  rx,
  input  logic [data_width-1:0] data_in,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic                  framing_error,
  output logic                  parity_error,
  output logic [data_width-1:0] data_out
);

  localparam int unsigned ClksPerBit = calc_clks_per_bit(clk_freq, baud_rate);

  uart_tx #(
    .clks_per_bit(ClksPerBit),
    .data_width  (data_width)
  ) u_tx (
    .clk              (clk),
    .rst              (rst),
    .tx_en            (tx_en),
    .baud_en          (baud_en),
    .parity_en        (parity_en),
    .odd_r_even_parity(odd_r_even_parity),
    .data_in          (data_in),
    .tx               (tx),
    .busy             (busy)
  );

  uart_rx #(
    .clks_per_bit(ClksPerBit),
    .data_width  (data_width)
  ) u_rx (
    .clk              (clk),
    .rst              (rst),
    .rx               (rx),
    .baud_en          (baud_en),
    .parity_en        (parity_en),
    .odd_r_even_parity(odd_r_even_parity),
    .done             (done),
    .framing_error    (framing_error),
    .parity_error     (parity_error),
    .data_out         (data_out)
  );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed loopback and injected-frame bench for uart_txrx with a short bit time.
module tb_uart_txrx;

  localparam int unsigned ClkFreq  = 160;
  localparam int unsigned BaudRate = 10;
  localparam int          Cpb      = 16;
  localparam int          Stall    = 20;

  logic       clk = 1'b0;
  logic       rst, tx_en, baud_en, parity_en, odd_r_even_parity;
  logic       rx, tx, busy, done, framing_error, parity_error;
  logic [7:0] data_in, data_out;
  logic       loop, rx_drv;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  assign rx = loop ? tx : rx_drv;

  uart_txrx #(
    .clk_freq  (ClkFreq),
    .baud_rate (BaudRate),
    .data_width(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tx_en            (tx_en),
    .baud_en          (baud_en),
    .parity_en        (parity_en),
    .odd_r_even_parity(odd_r_even_parity),
    .rx               (rx),
    .data_in          (data_in),
    .tx               (tx),
    .busy             (busy),
    .done             (done),
    .framing_error    (framing_error),
    .parity_error     (parity_error),
    .data_out         (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int start_cnt);
    int k;
    k = 0;
    while (done_cnt == start_cnt && k < 4 * Cpb) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, " done"}, done_cnt - start_cnt, 1);
  endtask

  task automatic start_tx(input string tag, input logic [7:0] data, input logic pen,
                          input logic odd);
    bit seen;
    seen              = 1'b0;
    data_in           = data;
    parity_en         = pen;
    odd_r_even_parity = odd;
    tx_en             = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    tx_en = 1'b0;
    check_eq({tag, " busy"}, seen, 1);
  endtask

  // Loopback frame: checks each tx bit at its centre, then the received result.
  task automatic send_frame(input string tag, input logic [7:0] data, input logic pen,
                            input logic odd, input logic exp_par);
    int d0;
    int k;
    d0   = done_cnt;
    loop = 1'b1;
    start_tx(tag, data, pen, odd);
    check_eq({tag, " start_early"}, tx, 0);
    repeat (Cpb / 2) @(negedge clk);
    check_eq({tag, " start"}, tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (Cpb) @(negedge clk);
      check_eq($sformatf("%s d%0d", tag, i), tx, data[i]);
    end
    if (pen) begin
      repeat (Cpb) @(negedge clk);
      check_eq({tag, " parity_bit"}, tx, exp_par);
    end
    repeat (Cpb) @(negedge clk);
    check_eq({tag, " stop"}, tx, 1);
    wait_done(tag, d0);
    check_eq({tag, " data_out"}, data_out, data);
    check_eq({tag, " ferr"}, framing_error, 0);
    check_eq({tag, " perr"}, parity_error, 0);
    k = 0;
    while (busy && k < 2 * Cpb) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, " busy_low"}, busy, 0);
  endtask

  task automatic drive_rx_frame(input string tag, input logic [7:0] data, input logic pen,
                                input logic pbit, input logic stop, input logic exp_ferr,
                                input logic exp_perr);
    int d0;
    d0                = done_cnt;
    loop              = 1'b0;
    parity_en         = pen;
    odd_r_even_parity = 1'b0;
    rx_drv            = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = data[i];
      repeat (Cpb) @(negedge clk);
    end
    if (pen) begin
      rx_drv = pbit;
      repeat (Cpb) @(negedge clk);
    end
    rx_drv = stop;
    repeat (Cpb) @(negedge clk);
    rx_drv = 1'b1;
    wait_done(tag, d0);
    check_eq({tag, " data_out"}, data_out, data);
    check_eq({tag, " ferr"}, framing_error, exp_ferr);
    check_eq({tag, " perr"}, parity_error, exp_perr);
    repeat (2 * Cpb) @(negedge clk);
  endtask

  initial begin
    int  d0;
    int  n;
    int  changes;
    logic hold;

    rst               = 1'b1;
    tx_en             = 1'b0;
    baud_en           = 1'b1;
    parity_en         = 1'b0;
    odd_r_even_parity = 1'b0;
    data_in           = 8'h00;
    loop              = 1'b1;
    rx_drv            = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst tx", tx, 1);
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst ferr", framing_error, 0);
    check_eq("rst perr", parity_error, 0);
    check_eq("rst data_out", data_out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_frame("plain_250", 8'd250, 1'b0, 1'b0, 1'b0);
    send_frame("even_251", 8'd251, 1'b1, 1'b0, 1'b1);
    send_frame("odd_252", 8'd252, 1'b1, 1'b1, 1'b1);
    send_frame("even_250", 8'd250, 1'b1, 1'b0, 1'b0);

    drive_rx_frame("bad_stop", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // 0xA5 has four ones, so correct even parity is 0; drive 1.
    drive_rx_frame("bad_par", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    d0     = done_cnt;
    loop   = 1'b0;
    rx_drv = 1'b0;
    repeat (Cpb / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * Cpb) @(negedge clk);
    check_eq("glitch no_done", done_cnt - d0, 0);
    drive_rx_frame("after_glitch", 8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    loop = 1'b1;
    start_tx("rst_mid", 8'h0F, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid tx", tx, 1);
    check_eq("rst_mid busy", busy, 0);
    check_eq("rst_mid data_out", data_out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame("post_rst", 8'h3C, 1'b0, 1'b0, 1'b0);

    d0 = done_cnt;
    start_tx("stall", 8'd250, 1'b0, 1'b0);
    n       = 1;
    changes = 0;
    hold    = 1'b1;
    while (busy && n < 20 * Cpb) begin
      if (n == 3 * Cpb + Cpb / 2) begin
        hold    = tx;
        baud_en = 1'b0;
        repeat (Stall) begin
          @(negedge clk);
          n++;
          if (tx !== hold) changes++;
        end
        baud_en = 1'b1;
      end
      @(negedge clk);
      if (busy) n++;
    end
    check_eq("stall held_bit", hold, 0);
    check_eq("stall tx_changes", changes, 0);
    check_eq("stall frame_len", n, 10 * Cpb + Stall);
    wait_done("stall", d0);
    check_eq("stall data_out", data_out, 8'd250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
